// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO stream reader and its skid buffer.
// Latency: n/a (package only).
// Backpressure: n/a.
package fifo_stream_reader_pkg;

  // Skid buffer depth: covers the one-cycle FIFO read latency plus a full-rate pipeline.
  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] ptr_t;

  // Circular pointer increment for a 3-entry buffer: 0 -> 1 -> 2 -> 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/skid_buffer_3.sv
// 3-entry circular skid buffer: storage, head/tail pointers and occupancy.
// Latency: a push is visible at o_data/o_occ the cycle after the push edge.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module skid_buffer_3
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  ptr_t                  r_head;
  ptr_t                  r_tail;
  logic [1:0]            r_occ;

  // Storage write at the tail; cleared on reset so the head word reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_tail <= ptr_inc(r_tail);
      if (i_pop)  r_head <= ptr_inc(r_head);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data = r_mem[r_head];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and presents the words as a valid/ready stream with burst framing.
// Latency: output valid two cycles after the cycle fifo_rd_en is high (empty buffer); 1 word/cycle sustained.
// Backpressure: m_ready stalls the output; pops stop once buffered + in-flight words reach 3, never combinationally from m_ready.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  output logic [CNT_WIDTH-1:0]  o_words_out
);

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  logic                 r_run;
  logic                 r_inflight;
  logic [15:0]          r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_words_out;

  logic [1:0]            w_occ;
  logic [2:0]            w_fill;
  logic                  w_rd_en;
  logic                  w_valid;
  logic                  w_hs;
  logic [DATA_WIDTH-1:0] w_head_data;

  // Reserve a buffer slot for every word already popped but not yet landed.
  assign w_fill  = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_rd_en = r_run & i_enable & ~i_fifo_empty & (w_fill < 3'(SKID_DEPTH));
  assign w_valid = (w_occ != 2'd0);
  assign w_hs    = w_valid & i_m_ready;

  skid_buffer_3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (r_inflight),
    .i_push_data (i_fifo_data),
    .i_pop       (w_hs),
    .o_data      (w_head_data),
    .o_occ       (w_occ)
  );

  // run_q holds pops off until the first edge after reset release; inflight tracks the pending read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_rd_en;
    end
  end

  // Burst position and delivered-word count advance on every accepted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt  <= '0;
      r_words_out <= '0;
    end else if (w_hs) begin
      r_beat_cnt  <= (r_beat_cnt == LAST_BEAT) ? 16'd0 : r_beat_cnt + 16'd1;
      r_words_out <= r_words_out + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) w_fill <= 3'(SKID_DEPTH));

  assign o_fifo_rd_en = w_rd_en;
  assign o_m_valid    = w_valid;
  assign o_m_data     = w_head_data;
  assign o_m_last     = w_valid & (r_beat_cnt == LAST_BEAT);
  assign o_words_out  = r_words_out;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a behavioural FIFO read port.
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   words_out;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (enable),
    .o_fifo_rd_en (fifo_rd_en),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_m_last     (m_last),
    .o_words_out  (words_out)
  );

  // Behavioural FIFO: data one cycle after the pop, contents dropped on reset.
  logic [DW-1:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Observation log
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            hs_cyc[$];
  logic          rd_hist [0:63];
  logic          vld_hist [0:63];
  int            cyc, n_pops, stall_viol;
  logic          prv_stall;
  logic [DW-1:0] prv_d;
  logic          prv_l;

  task automatic push(input logic [DW-1:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_log();
    got_d.delete(); got_l.delete(); hs_cyc.delete();
    cyc = 0; n_pops = 0; stall_viol = 0; prv_stall = 1'b0;
  endtask

  // Called at a falling edge with inputs set; observes the cycle and advances to the next falling edge.
  task automatic tick();
    #1;
    if (prv_stall && (!m_valid || m_data !== prv_d || m_last !== prv_l)) stall_viol++;
    prv_stall = m_valid && !m_ready;
    prv_d = m_data;
    prv_l = m_last;
    if (cyc < 64) begin rd_hist[cyc] = fifo_rd_en; vld_hist[cyc] = m_valid; end
    if (fifo_rd_en) n_pops++;
    if (m_valid && m_ready) begin
      got_d.push_back(m_data); got_l.push_back(m_last); hs_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = budget;
    while (got_d.size() < n && b > 0) begin tick(); b--; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    tick();
  endtask

  task automatic test_reset();
    int pop1, vld1;
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data got=%0h exp=0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got=%0b exp=0", m_last); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got=%0b exp=0", fifo_rd_en); end
    n_cmp++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL rst_words_out got=%0d exp=0", words_out); end
    @(negedge clk);
    push(8'h11); push(8'h22); push(8'h33);
    reset_n = 1'b1;
    clear_log();
    repeat (10) tick();
    pop1 = -1; vld1 = -1;
    for (int c = 0; c < 10; c++) begin
      if (pop1 < 0 && rd_hist[c] === 1'b1) pop1 = c;
      if (vld1 < 0 && vld_hist[c] === 1'b1) vld1 = c;
    end
    n_cmp++; if (rd_hist[0] !== 1'b0) begin n_fail++; $display("FAIL rel_rd_en_cycle0 got=%0b exp=0", rd_hist[0]); end
    n_cmp++; if (pop1 != 1) begin n_fail++; $display("FAIL rel_first_pop_cycle got=%0d exp=1", pop1); end
    n_cmp++; if (vld1 != 3) begin n_fail++; $display("FAIL rel_first_valid_cycle got=%0d exp=3", vld1); end
    n_cmp++; if (n_pops != 3) begin n_fail++; $display("FAIL rel_pops got=%0d exp=3", n_pops); end
    n_cmp++;
    if (got_d.size() != 3 || got_d[0] !== 8'h11 || got_d[1] !== 8'h22 || got_d[2] !== 8'h33) begin
      n_fail++; $display("FAIL rel_data got_n=%0d exp 11,22,33", got_d.size());
    end
    n_cmp++;
    if (hs_cyc.size() != 3 || hs_cyc[0] != 3 || hs_cyc[2] != 5) begin
      n_fail++; $display("FAIL rel_hs_cycles got_n=%0d exp cycles 3..5", hs_cyc.size());
    end
    n_cmp++; if (words_out !== 16'd3) begin n_fail++; $display("FAIL rel_words_out got=%0d exp=3", words_out); end
  endtask

  task automatic test_burst();
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    run_until(8, 40);
    n_cmp++; if (got_d.size() != 8) begin n_fail++; $display("FAIL burst_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== 8'hA0 + 8'(i) || got_l[i] !== ((i % 4) == 3)) begin
        n_fail++; $display("FAIL burst_word%0d got=%0h last=%0b exp=%0h last=%0b", i, got_d[i], got_l[i], 8'hA0 + 8'(i), (i % 4) == 3);
      end
    end
    n_cmp++;
    if (hs_cyc.size() != 8 || hs_cyc[7] - hs_cyc[0] != 7) begin
      n_fail++; $display("FAIL burst_throughput got_n=%0d exp 8 handshakes in 8 cycles", hs_cyc.size());
    end
    n_cmp++; if (words_out !== 16'd8) begin n_fail++; $display("FAIL burst_words_out got=%0d exp=8", words_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    repeat (10) tick();
    n_cmp++; if (n_pops != 3) begin n_fail++; $display("FAIL bp_pops got=%0d exp=3", n_pops); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en got=%0b exp=0", fifo_rd_en); end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h40) begin
      n_fail++; $display("FAIL bp_head got_vld=%0b data=%0h exp vld=1 data=40", m_valid, m_data);
    end
    n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable got=%0d exp=0 violations", stall_viol); end
    m_ready = 1'b1;
    run_until(8, 40);
    n_cmp++; if (got_d.size() != 8) begin n_fail++; $display("FAIL bp_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== 8'h40 + 8'(i)) begin
        n_fail++; $display("FAIL bp_word%0d got=%0h exp=%0h", i, got_d[i], 8'h40 + 8'(i));
      end
    end
    n_cmp++; if (n_pops != 8) begin n_fail++; $display("FAIL bp_total_pops got=%0d exp=8", n_pops); end
  endtask

  task automatic test_random_ready();
    int guard, bad;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 200; i++) push(8'(i));
    guard = 3000;
    while (got_d.size() < 200 && guard > 0) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      guard--;
    end
    n_cmp++; if (got_d.size() != 200) begin n_fail++; $display("FAIL rnd_count got=%0d exp=200", got_d.size()); end
    bad = -1;
    for (int i = 0; i < got_d.size(); i++)
      if (bad < 0 && (got_d[i] !== 8'(i) || got_l[i] !== ((i % 4) == 3))) bad = i;
    n_cmp++; if (bad != -1) begin n_fail++; $display("FAIL rnd_order first_bad_index got=%0d exp=-1", bad); end
    n_cmp++; if (words_out !== 16'd200) begin n_fail++; $display("FAIL rnd_words_out got=%0d exp=200", words_out); end
    n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL rnd_stable got=%0d exp=0 violations", stall_viol); end
  endtask

  task automatic test_enable();
    int p0, h0, bad;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(8'h80 + 8'(i));
    run_until(3, 20);
    p0 = n_pops; h0 = got_d.size();
    enable = 1'b0;
    repeat (5) tick();
    n_cmp++; if (n_pops != p0) begin n_fail++; $display("FAIL en_pops_while_off got=%0d exp=0", n_pops - p0); end
    n_cmp++; if (got_d.size() - h0 != 2) begin n_fail++; $display("FAIL en_drain got=%0d exp=2", got_d.size() - h0); end
    enable = 1'b1;
    run_until(12, 40);
    n_cmp++; if (got_d.size() != 12) begin n_fail++; $display("FAIL en_count got=%0d exp=12", got_d.size()); end
    bad = -1;
    for (int i = 0; i < got_d.size(); i++)
      if (bad < 0 && (got_d[i] !== 8'h80 + 8'(i) || got_l[i] !== ((i % 4) == 3))) bad = i;
    n_cmp++; if (bad != -1) begin n_fail++; $display("FAIL en_sequence first_bad_index got=%0d exp=-1", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    run_until(1, 20);
    m_ready = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%0b exp=1", m_valid); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_valid got=%0b exp=0", m_valid); end
    n_cmp++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL mid_words_out got=%0d exp=0", words_out); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rd_en got=%0b exp=0", fifo_rd_en); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    m_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    run_until(4, 30);
    n_cmp++; if (got_d.size() != 4) begin n_fail++; $display("FAIL mid_count got=%0d exp=4", got_d.size()); end
    bad = -1;
    for (int i = 0; i < got_d.size(); i++)
      if (bad < 0 && (got_d[i] !== 8'hD0 + 8'(i) || got_l[i] !== (i == 3))) bad = i;
    n_cmp++; if (bad != -1) begin n_fail++; $display("FAIL mid_new_burst first_bad_index got=%0d exp=-1", bad); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_burst();
    test_backpressure();
    test_random_ready();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drain-side companion to the team's synchronous FIFO. It issues pops on the FIFO read interface (rd_en/empty, with data appearing one cycle after the pop) and presents the words as a valid/ready stream. A 3-entry skid buffer hides the FIFO read latency, so throughput is 1 word/cycle with no combinational path from m_ready to fifo_rd_en. It also adds burst framing (m_last) and a delivered-word counter.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO.
BURST_LEN, 4, words per burst; m_last flags every BURST_LEN-th word; legal range 1..65535.
CNT_WIDTH, 16, width of words_out counter.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  1 = allowed to pop the FIFO
fifo_rd_en  out  1  pop request to FIFO read port
fifo_data_i  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop
fifo_empty  in  1  FIFO empty flag
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts
m_data  out  DATA_WIDTH  output word
m_last  out  1  last word of a burst; qualified by m_valid
words_out  out  CNT_WIDTH  count of completed handshakes, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset, asynchronous on reset_n low: skid buffer emptied, occ=0, inflight=0, beat_cnt=0, words_out=0, run_q=0. Outputs m_valid=0, m_data=0, m_last=0, fifo_rd_en=0.
- run_q goes to 1 on the first clock edge after reset release. This ensures fifo_rd_en stays 0 during and immediately after reset.
- FIFO contract: a pop happens at the edge where fifo_rd_en=1 and fifo_empty=0. fifo_data_i carries that word during the following cycle.
- fifo_rd_en = run_q and enable and not fifo_empty and (occ + inflight < 3).
  - The term is combinational from registers, enable and fifo_empty only. It never depends on m_ready.
- inflight is a register: it takes the value of fifo_rd_en at each edge. When inflight=1, fifo_data_i is written into the buffer tail at the next edge.
- Skid buffer: 3-entry circular buffer with 2-bit head and tail pointers that wrap 2 to 0, and occ ranging 0..3.
  - Write condition: inflight.
  - Read condition: m_valid and m_ready.
  - Simultaneous write and read: occ unchanged, both pointers advance.
  - Overflow is impossible by construction. Assert that occ + inflight never exceeds 3.
- m_valid = (occ != 0). m_data = buffer[head].
  - While m_valid=1 and m_ready=0, m_data and m_last must hold stable.
- Latency: from a pop edge with an empty buffer, m_valid rises 2 edges later.
- Steady state (FIFO non-empty, m_ready=1, enable=1): one handshake every cycle.
- m_last = m_valid and (beat_cnt == BURST_LEN-1).
  - beat_cnt increments on each handshake and wraps to 0 after the last word. With BURST_LEN=1, m_last=1 on every word.
- words_out increments by 1 on each handshake.
- enable deasserted: no new pops. The in-flight word and all buffered words still drain normally. beat_cnt is not reset, so a burst resumes where it left off.
- fifo_empty mid-stream: pops stop. The stream pauses with m_valid=0 once the buffer is drained. There are no bubbles other than FIFO starvation, enable, or back-pressure.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO shares reset_n and loses its contents too.

Decomposition:
- Shared package: SKID_DEPTH=3 constant, plus a ptr_inc function (wraps 2 to 0) reused for head and tail.
- One natural sub-module: skid_buffer_3, holding storage, pointers and occ, with push/pop/data/occ ports.
- The top level holds run_q, inflight, fifo_rd_en logic, beat_cnt and words_out.

Test Plan:
- Reset release with the FIFO holding 0x11,0x22,0x33 and m_ready=1 → fifo_rd_en rises on cycle 1. m_valid rises 2 edges after the first pop. Output is 0x11,0x22,0x33 on consecutive cycles, words_out=3.
- 8 words in FIFO, BURST_LEN=4, m_ready=1 → m_last=1 on words 4 and 8 only. Throughput is 8 handshakes in 8 consecutive cycles.
- m_ready=0 for 10 cycles with the FIFO full → exactly 3 pops, then fifo_rd_en=0. m_data holds the first word stable. Releasing m_ready delivers all words in order, none lost or duplicated.
- Random m_ready (50%) over 200 words of incrementing data → output sequence 0..199 in order. m_data/m_last stable while stalled. words_out=200, and the occ+inflight assertion never fires.
- enable dropped for 5 cycles mid-stream → no pops while enable=0. Buffered words still drain. The next word after re-enable continues the sequence, and beat_cnt is preserved.
- reset_n pulsed low while occ=2 → m_valid=0, words_out=0 and fifo_rd_en=0 immediately. The first word after release starts a new burst with beat_cnt=0.
